// File: rtl/stoch_pkg.sv
// Shared types and constants for the stochastic arithmetic unit.
// LFSR geometry (x^31+x^28+1), operator/state encodings and default seeds.
package stoch_pkg;

    localparam int LFSR_W = 31;
    localparam int TAP_HI = 30;
    localparam int TAP_LO = 27;

    localparam logic [LFSR_W-1:0] SEED_A_DEF = 31'h0000_0001;
    localparam logic [LFSR_W-1:0] SEED_B_DEF = 31'h5EED_1234;

    typedef enum logic [1:0] {
        MODE_UMUL = 2'b00,
        MODE_BMUL = 2'b01,
        MODE_SADD = 2'b10,
        MODE_PASS = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[TAP_HI] ^ s[TAP_LO]};
    endfunction

endpackage

// File: rtl/stoch_lfsr.sv
// Free-running 31-bit Fibonacci LFSR used as a stochastic number generator source.
// load_i reloads SEED on the next edge; only the low OUT_W bits are exported.
module stoch_lfsr
    import stoch_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED  = SEED_A_DEF,
    parameter int                OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    output logic [OUT_W-1:0] state_o
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    assign lfsr_d  = load_i ? SEED : lfsr_next(lfsr_q);
    assign state_o = lfsr_q[OUT_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_q <= SEED;
        else     lfsr_q <= lfsr_d;
    end

endmodule

// File: rtl/stoch_arith_unit.sv
// Stochastic arithmetic unit: two LFSR SNGs, one selectable operator, windowed ones counter.
// Optional macro STOCH_RESEED_EN reloads both LFSRs when a request is accepted.
//
// state   | meaning
// ST_IDLE | waiting for start; operands latched on acceptance
// ST_RUN  | 2 fill cycles, then 2^WIN_LOG2 counted cycles, then conversion
// ST_DONE | result_valid high for one cycle, busy still high
module stoch_arith_unit
    import stoch_pkg::*;
#(
    parameter int                PROB_W   = 8,
    parameter int                WIN_LOG2 = 8,
    parameter logic [LFSR_W-1:0] SEED_A   = SEED_A_DEF,
    parameter logic [LFSR_W-1:0] SEED_B   = SEED_B_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [PROB_W-1:0] prob_a,
    input  logic [PROB_W-1:0] prob_b,
    output logic              busy,
    output logic [PROB_W-1:0] result,
    output logic              result_valid
);

    localparam int CNT_W = WIN_LOG2 + 1;
    localparam int TMR_W = WIN_LOG2 + 2;
    localparam logic [TMR_W-1:0] WIN_LEN  = TMR_W'(1 << WIN_LOG2);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'((1 << WIN_LOG2) + 2);

    state_e             state_q;
    mode_e              mode_q;
    logic [PROB_W-1:0]  pa_q, pb_q;
    logic [TMR_W-1:0]   tmr_q;
    logic [CNT_W-1:0]   ones_q;
    logic               busy_q, valid_q;
    logic [PROB_W-1:0]  result_q;
    logic               sng_a_q, sng_b_q, sel_q, op_q;

    logic [PROB_W:0]    lfsr_a;
    logic [PROB_W-1:0]  lfsr_b;
    logic               start_acc;
    logic               reseed;
    logic [WIN_LOG2-1:0] sat_d;
    logic [PROB_W-1:0]  result_d;

    assign start_acc = (state_q == ST_IDLE) && start;

`ifdef STOCH_RESEED_EN
    assign reseed = start_acc;
`else
    assign reseed = 1'b0;
`endif

    stoch_lfsr #(.SEED(SEED_A), .OUT_W(PROB_W + 1)) u_lfsr_a (
        .clk     (clk),
        .rst     (rst_n),
        .load_i  (reseed),
        .state_o (lfsr_a)
    );

    stoch_lfsr #(.SEED(SEED_B), .OUT_W(PROB_W)) u_lfsr_b (
        .clk     (clk),
        .rst     (rst_n),
        .load_i  (reseed),
        .state_o (lfsr_b)
    );

    // SNG stage; the MUX select is registered here so it stays aligned with the stream bits
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            sng_a_q <= 1'b0;
            sng_b_q <= 1'b0;
            sel_q   <= 1'b0;
        end else begin
            sng_a_q <= (lfsr_a[PROB_W-1:0] < pa_q);
            sng_b_q <= (lfsr_b < pb_q);
            sel_q   <= lfsr_a[PROB_W];
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            op_q <= 1'b0;
        end else begin
            case (mode_q)
                MODE_UMUL: op_q <= sng_a_q & sng_b_q;
                MODE_BMUL: op_q <= ~(sng_a_q ^ sng_b_q);
                MODE_SADD: op_q <= sel_q ? sng_b_q : sng_a_q;
                default:   op_q <= sng_a_q;
            endcase
        end
    end

    // A full-window count (MSB set) saturates to all ones before truncation
    assign sat_d    = ones_q[WIN_LOG2] ? '1 : ones_q[WIN_LOG2-1:0];
    assign result_d = sat_d[WIN_LOG2-1 -: PROB_W];

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_UMUL;
            pa_q     <= '0;
            pb_q     <= '0;
            tmr_q    <= '0;
            ones_q   <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_acc) begin
                        mode_q  <= mode_e'(mode);
                        pa_q    <= prob_a;
                        pb_q    <= prob_b;
                        tmr_q   <= TMR_LOAD;
                        ones_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (tmr_q == '0) begin
                        result_q <= result_d;
                        valid_q  <= 1'b1;
                        state_q  <= ST_DONE;
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                        if (tmr_q <= WIN_LEN) ones_q <= ones_q + CNT_W'(op_q);
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy         = busy_q;
    assign result       = result_q;
    assign result_valid = valid_q;

endmodule
